// File: rtl/pid_correction_core.sv
// Fixed-point PID controller producing the signed 32-bit correction word for the HPS PIO.
// One shared 32x16 multiplier is stepped through the P, I and D terms by a small FSM.
module pid_correction_core #(
    parameter int FRAC_BITS   = 8,
    parameter int INTEG_LIMIT = 16777216
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        sample_tick,
    input  logic        clear_integral,
    input  logic [31:0] setpoint,
    input  logic [31:0] position,
    input  logic [15:0] kp,
    input  logic [15:0] ki,
    input  logic [15:0] kd,
    output logic [31:0] correction,
    output logic        valid,
    output logic        busy,
    output logic        saturated,
    output logic        overrun
);

    typedef enum logic [2:0] {StIdle, StErr, StMulP, StMulI, StMulD, StSat} state_e;

    localparam logic signed [32:0] LimPos = 33'(INTEG_LIMIT);
    localparam logic signed [32:0] LimNeg = -LimPos;

    state_e             r_state;
    logic signed [31:0] r_sp;
    logic signed [31:0] r_pos;
    logic signed [31:0] r_err;
    logic signed [31:0] r_integ;
    logic signed [31:0] r_der;
    logic signed [31:0] r_eprev;
    logic signed [49:0] r_acc;
    logic        [31:0] r_correction;
    logic               r_valid;
    logic               r_busy;
    logic               r_saturated;
    logic               r_overrun;

    logic signed [32:0] w_err33;
    logic signed [31:0] w_err;
    logic signed [32:0] w_int33;
    logic signed [31:0] w_integ_next;
    logic signed [32:0] w_der33;
    logic signed [31:0] w_der;
    logic signed [31:0] w_mul_a;
    logic signed [15:0] w_mul_b;
    logic signed [47:0] w_prod;
    logic signed [49:0] w_prod50;
    logic signed [49:0] w_shift;
    logic               w_clip;
    logic        [31:0] w_sat_val;

    always_comb begin
        w_err33 = {r_sp[31], r_sp} - {r_pos[31], r_pos};
        if (w_err33[32] != w_err33[31]) begin
            w_err = w_err33[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end else begin
            w_err = w_err33[31:0];
        end

        // Anti-windup: integral clamped symmetrically before it is stored
        w_int33 = {r_integ[31], r_integ} + {w_err[31], w_err};
        if (w_int33 > LimPos) begin
            w_integ_next = LimPos[31:0];
        end else if (w_int33 < LimNeg) begin
            w_integ_next = LimNeg[31:0];
        end else begin
            w_integ_next = w_int33[31:0];
        end

        w_der33 = {w_err[31], w_err} - {r_eprev[31], r_eprev};
        if (w_der33[32] != w_der33[31]) begin
            w_der = w_der33[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end else begin
            w_der = w_der33[31:0];
        end
    end

    always_comb begin
        w_mul_a = r_err;
        w_mul_b = kp;
        case (r_state)
            StMulI: begin
                w_mul_a = r_integ;
                w_mul_b = ki;
            end
            StMulD: begin
                w_mul_a = r_der;
                w_mul_b = kd;
            end
            default: ;
        endcase
        w_prod   = w_mul_a * w_mul_b;
        w_prod50 = {{2{w_prod[47]}}, w_prod};
    end

    always_comb begin
        w_shift = r_acc >>> FRAC_BITS;
        w_clip  = !((&w_shift[49:31]) || !(|w_shift[49:31]));
        if (w_clip) begin
            w_sat_val = w_shift[49] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            w_sat_val = w_shift[31:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_sp         <= '0;
            r_pos        <= '0;
            r_err        <= '0;
            r_integ      <= '0;
            r_der        <= '0;
            r_eprev      <= '0;
            r_acc        <= '0;
            r_correction <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_saturated  <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (!enable) begin
            // Abort: everything but the sticky overrun flag returns to idle values
            r_state      <= StIdle;
            r_integ      <= '0;
            r_eprev      <= '0;
            r_acc        <= '0;
            r_correction <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_saturated  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (sample_tick && r_state != StIdle) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (sample_tick) begin
                        r_sp    <= setpoint;
                        r_pos   <= position;
                        r_busy  <= 1'b1;
                        r_state <= StErr;
                    end
                end
                StErr: begin
                    r_err   <= w_err;
                    r_integ <= w_integ_next;
                    r_der   <= w_der;
                    r_eprev <= w_err;
                    r_state <= StMulP;
                end
                StMulP: begin
                    r_acc   <= w_prod50;
                    r_state <= StMulI;
                end
                StMulI: begin
                    r_acc   <= r_acc + w_prod50;
                    r_state <= StMulD;
                end
                StMulD: begin
                    r_acc   <= r_acc + w_prod50;
                    r_state <= StSat;
                end
                StSat: begin
                    r_correction <= w_sat_val;
                    r_saturated  <= w_clip;
                    r_valid      <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
            if (clear_integral) begin
                r_integ <= '0;
            end
        end
    end

    assign correction = r_correction;
    assign valid      = r_valid;
    assign busy       = r_busy;
    assign saturated  = r_saturated;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_pid_correction_core.sv
// Scoreboard bench for pid_correction_core: directed ticks push expected results,
// a negedge monitor pops and compares on every valid pulse.
module tb_pid_correction_core;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        sample_tick;
    logic        clear_integral;
    logic [31:0] setpoint;
    logic [31:0] position;
    logic [15:0] kp;
    logic [15:0] ki;
    logic [15:0] kd;
    logic [31:0] correction;
    logic        valid;
    logic        busy;
    logic        saturated;
    logic        overrun;

    typedef struct {
        logic [31:0] corr;
        logic        sat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   valid_count = 0;
    int   vc_before;

    pid_correction_core dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .sample_tick    (sample_tick),
        .clear_integral (clear_integral),
        .setpoint       (setpoint),
        .position       (position),
        .kp             (kp),
        .ki             (ki),
        .kd             (kd),
        .correction     (correction),
        .valid          (valid),
        .busy           (busy),
        .saturated      (saturated),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            exp_t e;
            valid_count++;
            if (q.size() == 0) begin
                chk("unexpected_valid", correction, 32'hDEAD_BEEF);
            end else begin
                e = q.pop_front();
                chk("correction", correction, e.corr);
                chk("saturated", {31'd0, saturated}, {31'd0, e.sat});
                chk("busy_low_at_valid", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic set_gains(input logic [15:0] p, input logic [15:0] i, input logic [15:0] d);
        kp = p;
        ki = i;
        kd = d;
    endtask

    // Drop enable for one cycle to clear integral, e_prev and correction
    task automatic clear_state();
        enable = 1'b0;
        @(negedge clk);
        chk("enable_low_clears_correction", correction, 32'd0);
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic tick(input logic [31:0] sp, input logic [31:0] pos,
                        input logic [31:0] exp_c, input logic exp_s);
        exp_t e;
        e.corr = exp_c;
        e.sat  = exp_s;
        q.push_back(e);
        setpoint    = sp;
        position    = pos;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        chk("busy_after_tick", {31'd0, busy}, 32'd1);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        reset_n        = 1'b0;
        enable         = 1'b1;
        sample_tick    = 1'b0;
        clear_integral = 1'b0;
        setpoint       = '0;
        position       = '0;
        set_gains(16'h0000, 16'h0000, 16'h0000);
        repeat (2) @(negedge clk);
        chk("reset_correction", correction, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_saturated", {31'd0, saturated}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Proportional only
        set_gains(16'h0100, 16'h0000, 16'h0000);
        tick(32'd1000, 32'd400, 32'd600, 1'b0);
        chk("correction_holds", correction, 32'd600);

        // Integral: 0.5 * accumulated error
        clear_state();
        set_gains(16'h0000, 16'h0080, 16'h0000);
        tick(32'd100, 32'd0, 32'd50, 1'b0);
        tick(32'd100, 32'd0, 32'd100, 1'b0);
        tick(32'd100, 32'd0, 32'd150, 1'b0);
        tick(32'd100, 32'd0, 32'd200, 1'b0);
        clear_integral = 1'b1;
        @(negedge clk);
        clear_integral = 1'b0;
        tick(32'd100, 32'd0, 32'd50, 1'b0);

        // Derivative
        clear_state();
        set_gains(16'h0000, 16'h0000, 16'h0100);
        tick(32'd10, 32'd0, 32'd10, 1'b0);
        tick(32'd30, 32'd0, 32'd20, 1'b0);

        // Saturation at both rails, then floor rounding of a negative result
        clear_state();
        set_gains(16'h7FFF, 16'h0000, 16'h0000);
        tick(32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        tick(32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        set_gains(16'h0080, 16'h0000, 16'h0000);
        tick(32'd5, 32'd10, 32'hFFFF_FFFD, 1'b0);

        // Anti-windup at the default limit of 2^24
        clear_state();
        set_gains(16'h0000, 16'h0100, 16'h0000);
        tick(32'd10000000, 32'd0, 32'd10000000, 1'b0);
        tick(32'd10000000, 32'd0, 32'd16777216, 1'b0);
        tick(32'd10000000, 32'd0, 32'd16777216, 1'b0);

        // Overrun: second tick at edge 3 is ignored
        clear_state();
        set_gains(16'h0100, 16'h0000, 16'h0000);
        chk("overrun_clear_before", {31'd0, overrun}, 32'd0);
        vc_before = valid_count;
        begin
            exp_t e;
            e.corr = 32'd50;
            e.sat  = 1'b0;
            q.push_back(e);
        end
        setpoint    = 32'd50;
        position    = 32'd0;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        setpoint    = 32'd999;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (6) @(negedge clk);
        chk("overrun_one_valid", valid_count - vc_before, 32'd1);
        chk("overrun_set", {31'd0, overrun}, 32'd1);

        // Enable dropped at edge 3 aborts the computation
        vc_before   = valid_count;
        setpoint    = 32'd70;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_correction", correction, 32'd0);
        enable = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_valid", valid_count - vc_before, 32'd0);
        chk("overrun_kept", {31'd0, overrun}, 32'd1);

        // Asynchronous reset mid-computation
        vc_before   = valid_count;
        setpoint    = 32'd80;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_correction", correction, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_mid_no_valid", valid_count - vc_before, 32'd0);

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
